// File: rtl/fifo_wr_feeder.sv
// fifo_wr_feeder: write-side producer for the dual-clock sample FIFO.
// Accepts a length-framed stream of samples from an upstream valid/ready
// source and drives the FIFO write port while respecting the full flag.
// A two-entry buffer (the output register plus one skid register) keeps
// upstream ready driven only from registers. Frame progress is reported
// through busy/done flags and a count of words written.
module fifo_wr_feeder #(
  parameter int DATAWIDTH = 8,
  parameter int CNTW      = 5
) (
  input  logic                 iWCLK,
  input  logic                 iWRST,
  input  logic                 iSTART,
  input  logic [CNTW-1:0]      iLEN,
  input  logic                 iSVALID,
  input  logic [DATAWIDTH-1:0] iSDATA,
  output logic                 oSREADY,
  output logic [DATAWIDTH-1:0] oWDAT,
  output logic                 oWINC,
  input  logic                 iFULL,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic [CNTW-1:0]      oWCNT
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state_q;
  logic [CNTW-1:0]      len_q;
  logic [CNTW-1:0]      inCnt_q;
  logic [CNTW-1:0]      wcnt_q;
  logic [DATAWIDTH-1:0] wdat_q;
  logic [DATAWIDTH-1:0] skidD_q;
  logic                 winc_q;
  logic                 skidV_q;
  logic                 done_q;

  logic                 sready;
  logic                 accept;
  logic                 wrOk;
  logic                 lastWr;

  // Ready depends only on registers: the frame is active, the skid slot is
  // free, and the frame has not yet taken all of its words from upstream.
  assign sready = (state_q == XFER) & ~skidV_q & (inCnt_q != len_q);
  assign accept = iSVALID & sready;
  assign wrOk   = winc_q & ~iFULL;
  // In XFER len_q is never zero, so len_q-1 cannot underflow there.
  assign lastWr = wrOk & (wcnt_q == (len_q - CNTW'(1)));

  assign oSREADY = sready;
  assign oWDAT   = wdat_q;
  assign oWINC   = winc_q;
  assign oBUSY   = (state_q == XFER);
  assign oDONE   = done_q;
  assign oWCNT   = wcnt_q;

  // Frame control FSM together with the output register and skid buffer.
  always_ff @(posedge iWCLK or posedge iWRST) begin
    if (iWRST) begin
      state_q <= IDLE;
      len_q   <= '0;
      inCnt_q <= '0;
      wcnt_q  <= '0;
      wdat_q  <= '0;
      skidD_q <= '0;
      winc_q  <= 1'b0;
      skidV_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (iSTART) begin
            len_q   <= iLEN;
            inCnt_q <= '0;
            wcnt_q  <= '0;
            if (iLEN != '0) begin
              state_q <= XFER;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        XFER: begin
          if (accept) begin
            inCnt_q <= inCnt_q + CNTW'(1);
          end
          if (wrOk) begin
            wcnt_q <= wcnt_q + CNTW'(1);
          end
          if (lastWr) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase

      // The output register may take a new word whenever it is empty or its
      // word is being written this edge. The skid word is older than anything
      // upstream, so it always goes first; ready is low while the skid is full,
      // so both sources never compete on the same edge.
      if (~winc_q | ~iFULL) begin
        if (skidV_q) begin
          wdat_q  <= skidD_q;
          winc_q  <= 1'b1;
          skidV_q <= 1'b0;
        end else if (accept) begin
          wdat_q <= iSDATA;
          winc_q <= 1'b1;
        end else begin
          winc_q <= 1'b0;
        end
      end else if (accept) begin
        skidD_q <= iSDATA;
        skidV_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// tb_fifo_wr_feeder: randomized scoreboard bench for fifo_wr_feeder.
// The reference model tracks each frame as a length, counts of words
// accepted and written, and a queue of accepted words still owed to the FIFO.
module tb_fifo_wr_feeder;

  localparam int DATAWIDTH = 8;
  localparam int CNTW      = 5;

  logic                 iWCLK;
  logic                 iWRST;
  logic                 iSTART;
  logic [CNTW-1:0]      iLEN;
  logic                 iSVALID;
  logic [DATAWIDTH-1:0] iSDATA;
  logic                 oSREADY;
  logic [DATAWIDTH-1:0] oWDAT;
  logic                 oWINC;
  logic                 iFULL;
  logic                 oBUSY;
  logic                 oDONE;
  logic [CNTW-1:0]      oWCNT;

  int vecCnt = 0;
  int errCnt = 0;

  // Reference model state.
  logic [DATAWIDTH-1:0] expQ[$];
  bit mBusy   = 0;
  bit mDone   = 0;
  bit lastAcc = 0;
  int mLen    = 0;
  int mAcc    = 0;
  int mWr     = 0;

  fifo_wr_feeder #(
    .DATAWIDTH(DATAWIDTH),
    .CNTW(CNTW)
  ) dut (
    .iWCLK(iWCLK),
    .iWRST(iWRST),
    .iSTART(iSTART),
    .iLEN(iLEN),
    .iSVALID(iSVALID),
    .iSDATA(iSDATA),
    .oSREADY(oSREADY),
    .oWDAT(oWDAT),
    .oWINC(oWINC),
    .iFULL(iFULL),
    .oBUSY(oBUSY),
    .oDONE(oDONE),
    .oWCNT(oWCNT)
  );

  // Free-running write clock, 10 time units per period.
  initial iWCLK = 1'b0;
  always #5 iWCLK = ~iWCLK;

  function automatic void checkOutput(input string name, input int act, input int exp);
    vecCnt++;
    if (act != exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: on each falling edge compare DUT outputs with the model, then
  // advance the model by the handshakes that the next rising edge will commit.
  always @(negedge iWCLK) begin
    bit acc;
    bit wr;
    bit st;
    logic [DATAWIDTH-1:0] exp;
    if (iWRST) begin
      expQ.delete();
      mBusy   = 0;
      mDone   = 0;
      mLen    = 0;
      mAcc    = 0;
      mWr     = 0;
      lastAcc = 0;
      checkOutput("rstWinc", int'(oWINC), 0);
      checkOutput("rstWdat", int'(oWDAT), 0);
      checkOutput("rstSready", int'(oSREADY), 0);
      checkOutput("rstBusy", int'(oBUSY), 0);
      checkOutput("rstDone", int'(oDONE), 0);
      checkOutput("rstWcnt", int'(oWCNT), 0);
    end else begin
      checkOutput("busy", int'(oBUSY), int'(mBusy));
      checkOutput("done", int'(oDONE), int'(mDone));
      checkOutput("wcnt", int'(oWCNT), mWr);
      checkOutput("winc", int'(oWINC), int'(expQ.size() != 0));
      checkOutput("sready", int'(oSREADY),
                  int'(mBusy && (expQ.size() < 2) && (mAcc < mLen)));

      acc = iSVALID & oSREADY;
      wr  = oWINC & ~iFULL;
      st  = iSTART & ~mBusy;
      mDone = 0;

      if (wr) begin
        if (expQ.size() != 0) begin
          exp = expQ.pop_front();
          checkOutput("wdat", int'(oWDAT), int'(exp));
        end
        mWr++;
        if (mWr == mLen) begin
          mBusy = 0;
          mDone = 1;
        end
      end
      if (acc) begin
        expQ.push_back(iSDATA);
        mAcc++;
      end
      if (st) begin
        mLen = int'(iLEN);
        mAcc = 0;
        mWr  = 0;
        if (iLEN == '0) mDone = 1;
        else            mBusy = 1;
      end
      lastAcc = acc;
    end
  end

  // Runs one frame. fullFrom/fullCnt force iFULL high for a window of cycles,
  // restartAt pulses iSTART (iLEN=9) mid-frame, and resetAt asserts iWRST once
  // that many words have been written.
  task automatic applyStimulus(input int len, input int validPct, input int fullPct,
                               input int fullFrom, input int fullCnt, input int restartAt,
                               input logic [DATAWIDTH-1:0] base,
                               input logic [DATAWIDTH-1:0] step, input int resetAt);
    int idx;
    int cyc;
    bit resetHit;
    idx = 0;
    cyc = 0;
    resetHit = 0;
    @(posedge iWCLK); #1;
    iSTART  = 1'b1;
    iLEN    = CNTW'(len);
    iSVALID = 1'b0;
    iFULL   = 1'b0;
    @(posedge iWCLK); #1;
    iSTART = 1'b0;
    while (mBusy) begin
      if (resetAt >= 0 && mWr == resetAt) begin
        iWRST   = 1'b1;
        iSVALID = 1'b0;
        iSTART  = 1'b0;
        iFULL   = 1'b0;
        #1;
        checkOutput("rstNowWinc", int'(oWINC), 0);
        checkOutput("rstNowBusy", int'(oBUSY), 0);
        checkOutput("rstNowWcnt", int'(oWCNT), 0);
        repeat (2) @(posedge iWCLK);
        #1;
        iWRST = 1'b0;
        resetHit = 1;
        break;
      end
      if (cyc > 600) begin
        checkOutput("frameTimeout", cyc, 600);
        break;
      end
      if (lastAcc) idx++;
      iSVALID = ($urandom_range(99) < validPct);
      iSDATA  = base + step * DATAWIDTH'(idx);
      iFULL   = ((cyc >= fullFrom) && (cyc < fullFrom + fullCnt)) ? 1'b1
                : ($urandom_range(99) < fullPct);
      iSTART  = (cyc == restartAt);
      if (cyc == restartAt) iLEN = CNTW'(9);
      @(posedge iWCLK); #1;
      cyc++;
    end
    iSTART = 1'b0;
    if (!resetHit) begin
      checkOutput("endWcnt", int'(oWCNT), len);
    end
    // Upstream keeps offering data while idle; nothing may be taken or written.
    iSVALID = 1'b1;
    iSDATA  = $urandom_range(255);
    repeat (2) begin
      iFULL = $urandom_range(1);
      @(posedge iWCLK); #1;
    end
    iSVALID = 1'b0;
    iFULL   = 1'b0;
  endtask

  // Directed frames first, then a run of random frames.
  initial begin
    iWRST   = 1'b1;
    iSTART  = 1'b0;
    iLEN    = '0;
    iSVALID = 1'b0;
    iSDATA  = '0;
    iFULL   = 1'b0;
    repeat (3) @(posedge iWCLK);
    #1;
    iWRST = 1'b0;

    $display("[TB] T1 basic 4-word frame");
    applyStimulus(4, 100, 0, -1, 0, -1, 8'h11, 8'h11, -1);
    $display("[TB] T2 full stall with skid");
    applyStimulus(6, 100, 0, 2, 3, -1, 8'hA0, 8'h01, -1);
    $display("[TB] T3 zero-length frame");
    applyStimulus(0, 100, 0, -1, 0, -1, 8'h00, 8'h01, -1);
    $display("[TB] T4 restart ignored mid-frame");
    applyStimulus(3, 100, 0, -1, 0, 1, 8'h30, 8'h01, -1);
    $display("[TB] T5 valid gaps with random full");
    applyStimulus(4, 60, 30, -1, 0, -1, DATAWIDTH'($urandom_range(255)), 8'h01, -1);
    $display("[TB] T6 reset mid-frame then new frame");
    applyStimulus(5, 100, 0, -1, 0, -1, 8'h50, 8'h01, 2);
    applyStimulus(2, 100, 0, -1, 0, -1, 8'h60, 8'h01, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 25; f++) begin
      applyStimulus($urandom_range(31), 30 + $urandom_range(70), $urandom_range(50),
                    -1, 0, ($urandom_range(3) == 0) ? 2 : -1,
                    DATAWIDTH'($urandom_range(255)), DATAWIDTH'($urandom_range(255)), -1);
    end
    applyStimulus(31, 100, 0, -1, 0, -1, 8'h00, 8'h03, -1);

    repeat (2) @(posedge iWCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
